// File: rtl/dw_window_gen.sv
// Depthwise 3x3 window generator: shifts three aligned rows per channel into a
// column window and emits full windows, skipping borders and stride-skipped pixels.
module dw_window_gen #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CHANNEL_NUM = 18,
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned DEF_WIDTH   = 318,
    parameter int unsigned DEF_HEIGHT  = 318
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [CHANNEL_NUM*3*DATA_WIDTH-1:0]  data_in,
    input  logic                                 valid_in,
    input  logic [CNT_W-1:0]                     frame_width,
    input  logic [CNT_W-1:0]                     frame_height,
    input  logic                                 stride,
    input  logic                                 cfg_load,
    output logic [CHANNEL_NUM*9*DATA_WIDTH-1:0]  data_out,
    output logic                                 valid_out,
    output logic                                 last_col,
    output logic                                 frame_done
);

    localparam int unsigned OUT_W = CHANNEL_NUM * 9 * DATA_WIDTH;
    localparam int unsigned ROWS  = 3;

    // Columns 1 and 2 of the window; column 0 is the incoming pixel itself.
    logic [DATA_WIDTH-1:0] win [CHANNEL_NUM][ROWS][2];

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] height_q;
    logic             stride_q;

    logic             accept_c;
    logic             col_end_c;
    logic             row_end_c;
    logic             emit_c;
    logic [OUT_W-1:0] window_c;

    assign accept_c  = valid_in & ~cfg_load;
    assign col_end_c = (col == width_q - CNT_W'(1));
    assign row_end_c = (row == height_q - CNT_W'(1));
    assign emit_c    = accept_c && (col >= CNT_W'(2)) && (row >= CNT_W'(2))
                       && (!stride_q || (!col[0] && !row[0]));

    // Window as it will look after the current pixel shifts in.
    always_comb begin
        window_c = '0;
        for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
            for (int r = 0; r < ROWS; r++) begin
                window_c[(ch*9 + r*3)*DATA_WIDTH +: DATA_WIDTH] =
                    data_in[(r*CHANNEL_NUM + ch)*DATA_WIDTH +: DATA_WIDTH];
                window_c[(ch*9 + r*3 + 1)*DATA_WIDTH +: DATA_WIDTH] = win[ch][r][0];
                window_c[(ch*9 + r*3 + 2)*DATA_WIDTH +: DATA_WIDTH] = win[ch][r][1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                for (int r = 0; r < ROWS; r++) begin
                    win[ch][r][0] <= '0;
                    win[ch][r][1] <= '0;
                end
            end
        end else if (accept_c) begin
            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                for (int r = 0; r < ROWS; r++) begin
                    win[ch][r][1] <= win[ch][r][0];
                    win[ch][r][0] <= data_in[(r*CHANNEL_NUM + ch)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Frame geometry and position counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col      <= '0;
            row      <= '0;
            width_q  <= CNT_W'(DEF_WIDTH);
            height_q <= CNT_W'(DEF_HEIGHT);
            stride_q <= 1'b0;
        end else if (cfg_load) begin
            col      <= '0;
            row      <= '0;
            width_q  <= frame_width;
            height_q <= frame_height;
            stride_q <= stride;
        end else if (valid_in) begin
            if (col_end_c) begin
                col <= '0;
                row <= row_end_c ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            last_col   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= emit_c;
            last_col   <= emit_c && col_end_c;
            frame_done <= accept_c && col_end_c && row_end_c;
            if (emit_c) begin
                data_out <= window_c;
            end
        end
    end

endmodule

// File: doc/dw_window_gen.md
# dw_window_gen

Depthwise 3x3 window generator. Sits directly downstream of the depthwise row buffer: it consumes the three vertically aligned rows per channel that the row buffer emits each pixel, builds a 3-column shift window per channel, and presents complete 3x3 windows to the depthwise MAC array. It tracks column and row position within a frame and suppresses border windows and stride-skipped positions.

## Interface
- DATA_WIDTH, 8, bits per activation
- CHANNEL_NUM, 18, channels processed in parallel
- CNT_W, 9, width of column/row counters and frame dimension inputs
- DEF_WIDTH, 318, frame width after reset
- DEF_HEIGHT, 318, frame height after reset

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- data_in  in  CHANNEL_NUM*3*DATA_WIDTH  row r (0 = newest row, 2 = oldest) of channel ch at [(r*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH]
- valid_in  in  1  data_in carries one pixel column
- frame_width  in  CNT_W  columns per row, latched on cfg_load
- frame_height  in  CNT_W  rows per frame, latched on cfg_load
- stride  in  1  0 = stride 1, 1 = stride 2; latched on cfg_load
- cfg_load  in  1  latch config, clear position counters
- data_out  out  CHANNEL_NUM*9*DATA_WIDTH  tap k = r*3+c (r row, c column, 0 = newest) of channel ch at [(ch*9+k)*DATA_WIDTH +: DATA_WIDTH]
- valid_out  out  1  data_out holds a valid window
- last_col  out  1  with valid_out: window's right column is the last column of its row
- frame_done  out  1  one-cycle pulse: last pixel of frame accepted

## Operation
- Window storage per channel and row: three registers w[r][0..2]. On accepted valid_in: w[r][2]<=w[r][1], w[r][1]<=w[r][0], w[r][0]<=data_in row r. No shift when valid_in is low.
- Counters col, row (CNT_W bits). On accepted pixel: if col==width-1, col<=0 and (row==height-1 ? row<=0 : row<=row+1); else col<=col+1.
- Window is emitted for the accepted pixel iff col>=2 and row>=2 and (stride==0 or (col[0]==0 and row[0]==0)), using the pre-increment col/row of that pixel.
- Window registers are not cleared on row wrap; stale columns never reach a valid_out because col<2 windows are suppressed.
- last_col is set for an emitted window when col==width-1. frame_done is set when col==width-1 and row==height-1, whether or not that pixel emitted a window.
- cfg_load: latches frame_width/height/stride, clears col/row to 0; valid_out, last_col and frame_done are 0 the next cycle. Takes priority over a simultaneous valid_in, which is dropped (no shift, no count).
- Width or height <3: no window is ever emitted; counters still wrap and frame_done still pulses.
- Width and row arithmetic are unsigned CNT_W bits; a width of 0 is illegal (unspecified behaviour).

## Timing
- Latency 1: data_in/valid_in sampled at edge N; data_out, valid_out, last_col and frame_done update at edge N and are valid in the cycle after N. All outputs are registered.
- data_out holds its value when valid_out is 0. Consumers sample only on valid_out.
- No backpressure: one window per accepted pixel at most; full throughput with valid_in held high.
- Reset (asynchronous, any time incl. mid-frame): window registers, col, row, valid_out, last_col and frame_done are 0; width=DEF_WIDTH, height=DEF_HEIGHT, stride=0. The first pixel after reset is col 0, row 0.
- Back-to-back frames: the pixel following frame_done is col 0, row 0 of the next frame, with no idle cycle required.

## Test plan
- Stride 1, W=5, H=4, pixel value = row*16+col on all rows and channels, valid_in continuous -> exactly 6 valid_out; the first window follows pixel (2,2) and has taps r0c0=0x22, r0c2=0x20, r2c0=0x02 (row2 driven as row-2 data); last_col on windows at col 4; frame_done once, with the last window.
- Stride 2, W=7, H=7 -> exactly 9 windows, at (col,row) in {2,4,6}x{2,4,6}; none at odd positions.
- Same as the first scenario with valid_in randomly deasserted 50% -> identical window sequence and count; no shift during gaps.
- cfg_load asserted mid-frame together with valid_in -> input dropped, outputs 0 next cycle, next pixel treated as (0,0) with the new W/H/stride.
- rstn pulsed low mid-row -> all outputs 0 immediately; after release, default config applies and counting restarts at (0,0).
- Two consecutive W=4, H=3 frames with no gap -> 2 windows per frame, frame_done twice, and no window formed from the previous frame's columns.
